hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised read-after-write hazard tracker for the multi-port vertex-update pipeline.
//  Each accepted read opens an in-flight entry for its full address.
//  The matching write-back closes it.
//  Replaces the fixed 8-port per-bank flag scheme with a shared ENTRIES-deep scoreboard.
//  Adds:
//   - intra-batch duplicate detection
//   - same-cycle write bypass
//   - occupancy reporting
//   - timeout and orphan-write error flags
// PARAMETERS
//  ADDR_W     16  vertex address width; full-width compare, address 0 is a legal address
//  NUM_PORTS  8   read ports and write ports, one of each per lane, >=1
//  ENTRIES    16  in-flight scoreboard entries, >=NUM_PORTS
//  TIMEOUT_W  10  per-entry age counter width, >=2
// PORTS
//  clk            in   1                clock, all state on rising edge
//  rst            in   1                synchronous, active-high reset
//  rd_addr        in   NUM_PORTS*ADDR_W read addresses, lane p at [p*ADDR_W +: ADDR_W]
//  rd_valid       in   NUM_PORTS        read request per lane
//  wr_addr        in   NUM_PORTS*ADDR_W write-back addresses, same packing
//  wr_valid       in   NUM_PORTS        write-back per lane
//  stall          out  1                1 = read batch refused this cycle; upstream holds rd_* stable
//  hazard_vec     out  NUM_PORTS        per-lane hazard cause of stall
//  occupancy      out  $clog2(ENTRIES+1) valid entries (registered)
//  err_timeout    out  1                sticky: some entry reached max age
//  err_orphan_wr  out  1                sticky: write matched no entry
// BEHAVIOUR
//  - Entry state: valid, addr[ADDR_W], age[TIMEOUT_W].
//  - rst: all entries invalid, ages 0, occupancy 0, both err flags 0.
//    stall and hazard_vec are combinational, so they are 0 when rd_valid=0.
//  - Retire (every cycle, independent of stall):
//    - Each valid entry whose addr equals any wr_addr[q] with wr_valid[q] is cleared at the next edge.
//    - Duplicate writes to the same address clear it once.
//    - A valid write matching no valid entry sets err_orphan_wr at the next edge.
//  - Effective entries: valid entries not being retired this cycle.
//    A same-cycle write therefore bypasses and frees its entry for reads in the same cycle.
//  - hazard_vec[p] = rd_valid[p] & (
//      rd_addr[p] matches any effective entry, OR
//      rd_addr[p] == rd_addr[q] for some q<p with rd_valid[q] ).
//    The lowest-numbered duplicate lane is not flagged.
//  - full = popcount(rd_valid) > (ENTRIES - effective count).
//  - stall = |hazard_vec | full. Zero-cycle latency: combinational from inputs and registered state.
//  - Batch is all-or-nothing:
//    - stall=1: no entry allocated.
//    - stall=0: every valid lane is allocated at the next edge, in lane order, into the
//      lowest-index free slots (slots freed this cycle count as free). age set to 0.
//  - Age: each valid entry's age increments every cycle and saturates at 2^TIMEOUT_W-1.
//    Reaching saturation sets err_timeout. The entry is kept and still retirable.
//  - occupancy(next) = effective count + allocated count. It never exceeds ENTRIES.
//  - Err flags clear only on rst.
//  - rst asserted mid-operation discards all in-flight entries with no error.
// TESTING
//  1. rd lane0 0x0010 -> stall=0, occupancy=1 next cycle.
//     rd lane0 0x0010 again -> stall=1, hazard_vec=0x01.
//     Same cycle wr lane3 0x0010 -> stall=0, occupancy stays 1.
//  2. rd lanes 2 and 5 both 0x00AB, scoreboard empty -> hazard_vec=0x20, stall=1, occupancy stays 0.
//  3. Fill 16 distinct addresses:
//     - next rd 0x0100 -> stall=1, hazard_vec=0.
//     - add wr of one live address in the same cycle -> stall=0, occupancy stays 16.
//  4. rd 0x0000 accepted, rd 0x0000 again -> hazard_vec[0]=1. Address 0 is tracked like any other.
//  5. TIMEOUT_W=4, allocate one entry and never write -> err_timeout=1 after 15 cycles.
//     Entry still present; a later write retires it and occupancy returns to 0.
//  6. wr 0x0BAD with no entry -> err_orphan_wr=1 next cycle, occupancy unchanged.
//     Then rst with 5 entries live -> occupancy=0, both flags 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - read/write-back lanes and status of the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int ADDR_W    = 16,
    parameter int NUM_PORTS = 8,
    parameter int ENTRIES   = 16
);
    logic [NUM_PORTS*ADDR_W-1:0]  rd_addr;
    logic [NUM_PORTS-1:0]         rd_valid;
    logic [NUM_PORTS*ADDR_W-1:0]  wr_addr;
    logic [NUM_PORTS-1:0]         wr_valid;
    logic                         stall;
    logic [NUM_PORTS-1:0]         hazard_vec;
    logic [$clog2(ENTRIES+1)-1:0] occupancy;
    logic                         err_timeout;
    logic                         err_orphan_wr;

    modport master (
        output rd_addr, rd_valid, wr_addr, wr_valid,
        input  stall, hazard_vec, occupancy, err_timeout, err_orphan_wr
    );

    modport slave (
        input  rd_addr, rd_valid, wr_addr, wr_valid,
        output stall, hazard_vec, occupancy, err_timeout, err_orphan_wr
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shared in-flight RAW hazard scoreboard with same-cycle write bypass
module hazard_scoreboard #(
    parameter int ADDR_W    = 16,
    parameter int NUM_PORTS = 8,
    parameter int ENTRIES   = 16,
    parameter int TIMEOUT_W = 10
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam int                   CNT_W     = $clog2(ENTRIES + 1);
    localparam logic [TIMEOUT_W-1:0] AGE_MAX   = '1;
    localparam logic [CNT_W-1:0]     ENTRIES_C = CNT_W'(ENTRIES);

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q [ENTRIES];
    logic [ADDR_W-1:0]    addr_d [ENTRIES];
    logic [TIMEOUT_W-1:0] age_q  [ENTRIES];
    logic [TIMEOUT_W-1:0] age_d  [ENTRIES];
    logic [CNT_W-1:0]     occupancy_q, occupancy_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_orphan_q, err_orphan_d;

    logic [ENTRIES-1:0]   retire, eff, taken;
    logic [NUM_PORTS-1:0] wr_hit, hazard;
    logic [CNT_W-1:0]     eff_cnt, rd_cnt;
    logic                 full, stall, found;

    // Retiring entries are excluded before the read compare, giving write->read bypass.
    always_comb begin
        retire = '0;
        wr_hit = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (valid_q[e] && sb.wr_valid[q] &&
                    sb.wr_addr[q*ADDR_W +: ADDR_W] == addr_q[e]) begin
                    retire[e] = 1'b1;
                    wr_hit[q] = 1'b1;
                end
            end
        end
        eff     = valid_q & ~retire;
        eff_cnt = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            eff_cnt = eff_cnt + CNT_W'(eff[e]);
        end

        hazard = '0;
        rd_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sb.rd_valid[p]) begin
                rd_cnt = rd_cnt + CNT_W'(1);
                for (int e = 0; e < ENTRIES; e++) begin
                    if (eff[e] && addr_q[e] == sb.rd_addr[p*ADDR_W +: ADDR_W]) begin
                        hazard[p] = 1'b1;
                    end
                end
                for (int q = 0; q < p; q++) begin
                    if (sb.rd_valid[q] &&
                        sb.rd_addr[q*ADDR_W +: ADDR_W] == sb.rd_addr[p*ADDR_W +: ADDR_W]) begin
                        hazard[p] = 1'b1;
                    end
                end
            end
        end
        full  = rd_cnt > (ENTRIES_C - eff_cnt);
        stall = (|hazard) | full;
    end

    always_comb begin
        valid_d       = eff;
        addr_d        = addr_q;
        err_timeout_d = err_timeout_q;
        err_orphan_d  = err_orphan_q | (|(sb.wr_valid & ~wr_hit));
        taken         = eff;
        found         = 1'b0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (eff[e]) begin
                age_d[e] = (age_q[e] == AGE_MAX) ? AGE_MAX : age_q[e] + TIMEOUT_W'(1);
                if (age_d[e] == AGE_MAX) begin
                    err_timeout_d = 1'b1;
                end
            end else begin
                age_d[e] = '0;
            end
        end
        // Lanes claim free slots in lane order, lowest slot first.
        if (!stall) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sb.rd_valid[p]) begin
                    found = 1'b0;
                    for (int e = 0; e < ENTRIES; e++) begin
                        if (!found && !taken[e]) begin
                            found    = 1'b1;
                            taken[e] = 1'b1;
                            valid_d[e] = 1'b1;
                            addr_d[e]  = sb.rd_addr[p*ADDR_W +: ADDR_W];
                            age_d[e]   = '0;
                        end
                    end
                end
            end
        end
        occupancy_d = eff_cnt + (stall ? '0 : rd_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            occupancy_q   <= '0;
            err_timeout_q <= 1'b0;
            err_orphan_q  <= 1'b0;
            for (int e = 0; e < ENTRIES; e++) begin
                addr_q[e] <= '0;
                age_q[e]  <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            addr_q        <= addr_d;
            age_q         <= age_d;
            occupancy_q   <= occupancy_d;
            err_timeout_q <= err_timeout_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    assign sb.stall         = stall;
    assign sb.hazard_vec    = hazard;
    assign sb.occupancy     = occupancy_q;
    assign sb.err_timeout   = err_timeout_q;
    assign sb.err_orphan_wr = err_orphan_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard-checked bench for hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int AW = 16;
    localparam int NP = 8;
    localparam int NE = 16;
    localparam int TW = 4;

    typedef struct {
        string      name;
        logic       stall;
        logic [7:0] hz;
        logic [4:0] occ;
        logic       eto;
        logic       eor;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    hazard_scoreboard_if #(.ADDR_W(AW), .NUM_PORTS(NP), .ENTRIES(NE)) sb ();

    hazard_scoreboard #(.ADDR_W(AW), .NUM_PORTS(NP), .ENTRIES(NE), .TIMEOUT_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lane(int p, logic [15:0] a);
        logic [127:0] r;
        r = '0;
        r[p*16 +: 16] = a;
        return r;
    endfunction

    function automatic logic [127:0] fill(logic [15:0] base);
        logic [127:0] r;
        for (int i = 0; i < NP; i++) r[i*16 +: 16] = base + 16'(i);
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, req);
        end
    endtask

    task automatic step(string name, logic [7:0] rv, logic [127:0] ra,
                        logic [7:0] wv, logic [127:0] wa,
                        logic est, logic [7:0] ehz, logic [4:0] eocc, logic eto, logic eor);
        exp_t e;
        @(posedge clk);
        #1;
        sb.rd_valid = rv;
        sb.rd_addr  = ra;
        sb.wr_valid = wv;
        sb.wr_addr  = wa;
        e.name = name; e.stall = est; e.hz = ehz; e.occ = eocc; e.eto = eto; e.eor = eor;
        exp_q.push_back(e);
    endtask

    task automatic idle(string name, logic [4:0] eocc, logic eto, logic eor);
        step(name, 8'h00, '0, 8'h00, '0, 1'b0, 8'h00, eocc, eto, eor);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.rd_valid = '0;
        sb.wr_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every cycle that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".stall"}, 32'(sb.stall), 32'(e.stall));
                chk({e.name, ".hazard_vec"}, 32'(sb.hazard_vec), 32'(e.hz));
                chk({e.name, ".occupancy"}, 32'(sb.occupancy), 32'(e.occ));
                chk({e.name, ".err_timeout"}, 32'(sb.err_timeout), 32'(e.eto));
                chk({e.name, ".err_orphan_wr"}, 32'(sb.err_orphan_wr), 32'(e.eor));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb.rd_valid = '0;
        sb.rd_addr  = '0;
        sb.wr_valid = '0;
        sb.wr_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle("reset", 5'd0, 1'b0, 1'b0);

        // Basic hazard and same-cycle write bypass
        step("t1_alloc", 8'h01, lane(0, 16'h0010), 8'h00, '0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        step("t1_raw", 8'h01, lane(0, 16'h0010), 8'h00, '0, 1'b1, 8'h01, 5'd1, 1'b0, 1'b0);
        step("t1_bypass", 8'h01, lane(0, 16'h0010), 8'h08, lane(3, 16'h0010),
             1'b0, 8'h00, 5'd1, 1'b0, 1'b0);
        idle("t1_after", 5'd1, 1'b0, 1'b0);

        // Intra-batch duplicate: only the higher lane is flagged
        do_reset();
        step("t2_dup", 8'h24, lane(2, 16'h00AB) | lane(5, 16'h00AB), 8'h00, '0,
             1'b1, 8'h20, 5'd0, 1'b0, 1'b0);
        idle("t2_after", 5'd0, 1'b0, 1'b0);

        // Full scoreboard, freed slot reuse, duplicate writes retire once
        do_reset();
        step("t3_fill_a", 8'hFF, fill(16'h0200), 8'h00, '0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        step("t3_fill_b", 8'hFF, fill(16'h0208), 8'h00, '0, 1'b0, 8'h00, 5'd8, 1'b0, 1'b0);
        step("t3_full", 8'h01, lane(0, 16'h0100), 8'h00, '0, 1'b1, 8'h00, 5'd16, 1'b0, 1'b0);
        step("t3_free", 8'h01, lane(0, 16'h0100), 8'h02, lane(1, 16'h0203),
             1'b0, 8'h00, 5'd16, 1'b0, 1'b0);
        step("t3_dupwr", 8'h00, '0, 8'h03, lane(0, 16'h0200) | lane(1, 16'h0200),
             1'b0, 8'h00, 5'd16, 1'b0, 1'b0);
        idle("t3_after", 5'd15, 1'b0, 1'b0);

        // Address zero is tracked like any other
        do_reset();
        step("t4_alloc0", 8'h01, lane(0, 16'h0000), 8'h00, '0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        step("t4_raw0", 8'h01, lane(0, 16'h0000), 8'h00, '0, 1'b1, 8'h01, 5'd1, 1'b0, 1'b0);
        idle("t4_after", 5'd1, 1'b0, 1'b0);

        // Timeout: age reaches 15 on the 15th edge after allocation
        do_reset();
        step("t5_alloc", 8'h01, lane(0, 16'h0055), 8'h00, '0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        for (int k = 2; k <= 16; k++) idle($sformatf("t5_age%0d", k - 2), 5'd1, 1'b0, 1'b0);
        idle("t5_timeout", 5'd1, 1'b1, 1'b0);
        step("t5_retire", 8'h00, '0, 8'h10, lane(4, 16'h0055), 1'b0, 8'h00, 5'd1, 1'b1, 1'b0);
        idle("t5_after", 5'd0, 1'b1, 1'b0);

        // Orphan write, then reset with live entries
        do_reset();
        step("t6_orphan", 8'h00, '0, 8'h01, lane(0, 16'h0BAD), 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        idle("t6_flag", 5'd0, 1'b0, 1'b1);
        step("t6_alloc5", 8'h1F, fill(16'h0300), 8'h00, '0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1);
        idle("t6_live", 5'd5, 1'b0, 1'b1);
        do_reset();
        idle("t6_rst", 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
